move_sequencer: RTL and testbench

//  Owns the falling block's position (b_x, b_y, b_rotation) and is the sole driver of the move checker.

---
 rtl/move_sequencer_pkg.sv | 41 ++++
 rtl/move_sequencer_if.sv | 14 +
 rtl/move_sequencer_arbiter.sv | 68 ++++++
 rtl/move_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_move_sequencer.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/move_sequencer_pkg.sv
// Shared types, move codes and the move-delta helper for the move sequencer.
package move_sequencer_pkg;

    localparam int unsigned FIELD_COL_CNT_WIDTH = 4;
    localparam int unsigned FIELD_ROW_CNT_WIDTH = 5;
    localparam int unsigned BX_W                = FIELD_COL_CNT_WIDTH + 1;
    localparam int unsigned BY_W                = FIELD_ROW_CNT_WIDTH + 1;
    localparam int unsigned MOVE_W              = 3;

    localparam logic [MOVE_W-1:0] MOVE_LEFT   = 3'd1;
    localparam logic [MOVE_W-1:0] MOVE_RIGHT  = 3'd2;
    localparam logic [MOVE_W-1:0] MOVE_DOWN   = 3'd3;
    localparam logic [MOVE_W-1:0] MOVE_ROTATE = 3'd4;
    localparam logic [MOVE_W-1:0] MOVE_APPEAR = 3'd5;

    typedef logic [1:0] seq_state_t;
    localparam seq_state_t ST_IDLE  = 2'd0;
    localparam seq_state_t ST_ISSUE = 2'd1;
    localparam seq_state_t ST_WAIT  = 2'd2;

    typedef struct packed {
        logic signed [1:0] dx;
        logic signed [1:0] dy;
        logic        [1:0] drot;
    } move_delta_t;

    // Position change applied when a move is accepted (APPEAR handled separately).
    function automatic move_delta_t move_delta(input logic [MOVE_W-1:0] code);
        move_delta_t d;
        d = '0;
        case (code)
            MOVE_LEFT:   d.dx   = -2'sd1;
            MOVE_RIGHT:  d.dx   = 2'sd1;
            MOVE_DOWN:   d.dy   = 2'sd1;
            MOVE_ROTATE: d.drot = 2'd1;
            default:     d      = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/move_sequencer_if.sv
// Handshake between the move sequencer (master) and the move checker (slave).
interface move_sequencer_if;
    import move_sequencer_pkg::*;

    logic              check_run;
    logic [MOVE_W-1:0] check_req_move;
    logic              check_done;
    logic              check_can_move;

    modport master (output check_run, output check_req_move,
                    input  check_done, input check_can_move);
    modport slave  (input  check_run, input check_req_move,
                    output check_done, output check_can_move);
endinterface

// File: rtl/move_sequencer_arbiter.sv
// move_req_arbiter: pending request latches, priority select and user handshake.
module move_req_arbiter
    import move_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              appear_req_i,
    input  logic              gravity_tick_i,
    input  logic              user_valid_i,
    input  logic [MOVE_W-1:0] user_move_i,
    input  logic              idle_i,
    input  logic              block_active_i,
    input  logic              drop_grav_i,
    output logic              grant_valid_c,
    output logic [MOVE_W-1:0] grant_move_c,
    output logic              user_ready_c
);

    logic appear_pend_q, appear_pend_d;
    logic grav_pend_q, grav_pend_d;
    logic appear_eff, grav_eff, take_appear, take_grav, user_legal;

    // A request pulse is visible in the same cycle so an idle sequencer issues next cycle.
    assign appear_eff = appear_pend_q | appear_req_i;
    assign grav_eff   = grav_pend_q | gravity_tick_i;
    assign user_legal = user_move_i inside {MOVE_LEFT, MOVE_RIGHT, MOVE_DOWN, MOVE_ROTATE};

    // Priority: appear > gravity (only with a live block) > user.
    always_comb begin
        grant_valid_c = 1'b0;
        grant_move_c  = MOVE_LEFT;
        user_ready_c  = 1'b0;
        take_appear   = 1'b0;
        take_grav     = 1'b0;
        if (idle_i) begin
            if (appear_eff) begin
                grant_valid_c = 1'b1;
                grant_move_c  = MOVE_APPEAR;
                take_appear   = 1'b1;
            end else if (grav_eff && block_active_i) begin
                grant_valid_c = 1'b1;
                grant_move_c  = MOVE_DOWN;
                take_grav     = 1'b1;
            end else begin
                user_ready_c = 1'b1;
                // Moves without a falling block (or illegal codes) are consumed and dropped.
                if (user_valid_i && block_active_i && user_legal) begin
                    grant_valid_c = 1'b1;
                    grant_move_c  = user_move_i;
                end
            end
        end
        appear_pend_d = appear_eff & ~take_appear;
        grav_pend_d   = grav_eff & ~take_grav & ~drop_grav_i;
    end

    // Pending flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            appear_pend_q <= 1'b0;
            grav_pend_q   <= 1'b0;
        end else begin
            appear_pend_q <= appear_pend_d;
            grav_pend_q   <= grav_pend_d;
        end
    end

endmodule

// File: rtl/move_sequencer.sv
// move_sequencer: owns the falling block position and runs one checker transaction at a time.
module move_sequencer
    import move_sequencer_pkg::*;
#(
    parameter int SPAWN_X      = 4,
    parameter int SPAWN_Y      = 0,
    parameter int DONE_TIMEOUT = 31
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   appear_req,
    input  logic                   gravity_tick,
    input  logic                   user_valid,
    input  logic [MOVE_W-1:0]      user_move,
    output logic                   user_ready,
    move_sequencer_if.master       chk,
    output logic signed [BX_W-1:0] b_x,
    output logic signed [BY_W-1:0] b_y,
    output logic [1:0]             b_rotation,
    output logic                   block_active,
    output logic                   busy,
    output logic                   landed,
    output logic                   game_over,
    output logic                   timeout_err
);

    localparam int unsigned CNT_W = $clog2(DONE_TIMEOUT + 1);

    seq_state_t            state_q, state_d;
    logic [MOVE_W-1:0]     move_q, move_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic signed [BX_W-1:0] x_q, x_d, sv_x_q, sv_x_d;
    logic signed [BY_W-1:0] y_q, y_d, sv_y_q, sv_y_d;
    logic [1:0]            rot_q, rot_d, sv_rot_q, sv_rot_d;
    logic                  active_q, active_d;
    logic                  run_q, run_d, busy_q, busy_d;
    logic                  landed_q, landed_d, over_q, over_d, tmo_q, tmo_d;
    logic                  grant_valid_c, drop_grav_c;
    logic [MOVE_W-1:0]     grant_move_c;
    move_delta_t           dlt;

    move_req_arbiter u_arb (
        .clk            (clk),
        .rst            (rst),
        .appear_req_i   (appear_req),
        .gravity_tick_i (gravity_tick),
        .user_valid_i   (user_valid),
        .user_move_i    (user_move),
        .idle_i         (state_q == ST_IDLE),
        .block_active_i (active_q),
        .drop_grav_i    (drop_grav_c),
        .grant_valid_c  (grant_valid_c),
        .grant_move_c   (grant_move_c),
        .user_ready_c   (user_ready)
    );

    // Next-state, position commit/refusal and watchdog.
    always_comb begin
        state_d     = state_q;
        move_d      = move_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        y_d         = y_q;
        rot_d       = rot_q;
        sv_x_d      = sv_x_q;
        sv_y_d      = sv_y_q;
        sv_rot_d    = sv_rot_q;
        active_d    = active_q;
        tmo_d       = tmo_q;
        run_d       = 1'b0;
        busy_d      = 1'b0;
        landed_d    = 1'b0;
        over_d      = 1'b0;
        drop_grav_c = 1'b0;
        dlt         = move_delta(move_q);
        case (state_q)
            ST_IDLE: begin
                if (grant_valid_c) begin
                    state_d = ST_ISSUE;
                    move_d  = grant_move_c;
                    cnt_d   = '0;
                    run_d   = 1'b1;
                    busy_d  = 1'b1;
                    // Show spawn coordinates to the checker; keep the old ones for a refusal.
                    if (grant_move_c == MOVE_APPEAR) begin
                        sv_x_d   = x_q;
                        sv_y_d   = y_q;
                        sv_rot_d = rot_q;
                        x_d      = BX_W'(SPAWN_X);
                        y_d      = BY_W'(SPAWN_Y);
                        rot_d    = 2'd0;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                busy_d  = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_WAIT: begin
                busy_d = 1'b1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (chk.check_done || (cnt_q == CNT_W'(DONE_TIMEOUT - 1))) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    if (!chk.check_done) tmo_d = 1'b1;
                    if (chk.check_done && chk.check_can_move) begin
                        if (move_q == MOVE_APPEAR) begin
                            active_d = 1'b1;
                        end else begin
                            x_d   = x_q + BX_W'(dlt.dx);
                            y_d   = y_q + BY_W'(dlt.dy);
                            rot_d = rot_q + dlt.drot;
                        end
                    end else begin
                        if (move_q == MOVE_DOWN) begin
                            landed_d    = 1'b1;
                            active_d    = 1'b0;
                            drop_grav_c = 1'b1;
                        end else if (move_q == MOVE_APPEAR) begin
                            over_d = 1'b1;
                            x_d    = sv_x_q;
                            y_d    = sv_y_q;
                            rot_d  = sv_rot_q;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, position and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            move_q   <= MOVE_LEFT;
            cnt_q    <= '0;
            x_q      <= BX_W'(SPAWN_X);
            y_q      <= BY_W'(SPAWN_Y);
            rot_q    <= 2'd0;
            sv_x_q   <= BX_W'(SPAWN_X);
            sv_y_q   <= BY_W'(SPAWN_Y);
            sv_rot_q <= 2'd0;
            active_q <= 1'b0;
            run_q    <= 1'b0;
            busy_q   <= 1'b0;
            landed_q <= 1'b0;
            over_q   <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            move_q   <= move_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            rot_q    <= rot_d;
            sv_x_q   <= sv_x_d;
            sv_y_q   <= sv_y_d;
            sv_rot_q <= sv_rot_d;
            active_q <= active_d;
            run_q    <= run_d;
            busy_q   <= busy_d;
            landed_q <= landed_d;
            over_q   <= over_d;
            tmo_q    <= tmo_d;
        end
    end

    assign chk.check_run      = run_q;
    assign chk.check_req_move = move_q;
    assign b_x                = x_q;
    assign b_y                = y_q;
    assign b_rotation         = rot_q;
    assign block_active       = active_q;
    assign busy               = busy_q;
    assign landed             = landed_q;
    assign game_over          = over_q;
    assign timeout_err        = tmo_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer; the bench plays the move checker by hand.
module tb_move_sequencer;
    import move_sequencer_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   appear_req, gravity_tick, user_valid;
    logic [MOVE_W-1:0]      user_move;
    logic                   user_ready;
    logic signed [BX_W-1:0] b_x;
    logic signed [BY_W-1:0] b_y;
    logic [1:0]             b_rotation;
    logic                   block_active, busy, landed, game_over, timeout_err;
    int                     checks = 0;
    int                     errors = 0;

    move_sequencer_if chk_if ();

    move_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .appear_req   (appear_req),
        .gravity_tick (gravity_tick),
        .user_valid   (user_valid),
        .user_move    (user_move),
        .user_ready   (user_ready),
        .chk          (chk_if),
        .b_x          (b_x),
        .b_y          (b_y),
        .b_rotation   (b_rotation),
        .block_active (block_active),
        .busy         (busy),
        .landed       (landed),
        .game_over    (game_over),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bounded wait for the start pulse, then check the move code presented with it.
    task automatic wait_run(input string tag, input logic [MOVE_W-1:0] mv);
        int n;
        n = 0;
        while (chk_if.check_run !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        chk({tag, "_run"}, 32'(chk_if.check_run), 32'd1);
        chk({tag, "_mv"}, 32'(chk_if.check_req_move), 32'(mv));
        chk({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    // Called in the ISSUE cycle: wait lat cycles, then pulse check_done with a verdict.
    task automatic answer(input logic can, input int lat);
        repeat (lat) tick();
        chk_if.check_done     = 1'b1;
        chk_if.check_can_move = can;
        tick();
        chk_if.check_done     = 1'b0;
        chk_if.check_can_move = 1'b0;
    endtask

    task automatic user_req(input logic [MOVE_W-1:0] mv);
        user_valid = 1'b1;
        user_move  = mv;
        #1;
        tick();
        user_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b1; appear_req = 1'b0; gravity_tick = 1'b0; user_valid = 1'b0;
        user_move = MOVE_LEFT; chk_if.check_done = 1'b0; chk_if.check_can_move = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_bx", 32'(b_x), 32'd4);
        chk("rst_by", 32'(b_y), 32'd0);
        chk("rst_rot", 32'(b_rotation), 32'd0);
        chk("rst_act", 32'(block_active), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_run", 32'(chk_if.check_run), 32'd0);
        chk("rst_tmo", 32'(timeout_err), 32'd0);
        chk("rst_rdy", 32'(user_ready), 32'd1);

        // 1: spawn accepted
        appear_req = 1'b1;
        tick();
        appear_req = 1'b0;
        wait_run("appear", MOVE_APPEAR);
        answer(1'b1, 3);
        chk("appear_bx", 32'(b_x), 32'd4);
        chk("appear_by", 32'(b_y), 32'd0);
        chk("appear_act", 32'(block_active), 32'd1);
        chk("appear_busy", 32'(busy), 32'd0);

        // 2: left accepted, right refused
        user_req(MOVE_LEFT);
        wait_run("left", MOVE_LEFT);
        answer(1'b1, 2);
        chk("left_bx", 32'(b_x), 32'd3);
        user_req(MOVE_RIGHT);
        wait_run("right", MOVE_RIGHT);
        answer(1'b0, 2);
        chk("right_bx", 32'(b_x), 32'd3);
        chk("right_landed", 32'(landed), 32'd0);

        // 3: rotation wraps 3->0
        for (int i = 0; i < 4; i++) begin
            user_req(MOVE_ROTATE);
            wait_run("rot", MOVE_ROTATE);
            answer(1'b1, 1);
            chk("rot_val", 32'(b_rotation), 32'((i + 1) % 4));
        end

        // 4: gravity beats user; ticks during WAIT coalesce into one DOWN
        gravity_tick = 1'b1;
        user_valid   = 1'b1;
        user_move    = MOVE_LEFT;
        #1;
        chk("grav_rdy", 32'(user_ready), 32'd0);
        tick();
        gravity_tick = 1'b0;
        wait_run("grav1", MOVE_DOWN);
        tick();
        gravity_tick = 1'b1;
        tick(); tick(); tick();
        gravity_tick = 1'b0;
        chk_if.check_done     = 1'b1;
        chk_if.check_can_move = 1'b1;
        tick();
        chk_if.check_done     = 1'b0;
        chk_if.check_can_move = 1'b0;
        chk("grav1_by", 32'(b_y), 32'd1);
        chk("grav1_rdy", 32'(user_ready), 32'd0);
        tick();
        wait_run("grav2", MOVE_DOWN);
        answer(1'b1, 2);
        chk("grav2_by", 32'(b_y), 32'd2);
        chk("grav2_rdy", 32'(user_ready), 32'd1);
        tick();
        user_valid = 1'b0;
        wait_run("user_after", MOVE_LEFT);
        answer(1'b1, 1);
        chk("user_after_bx", 32'(b_x), 32'd2);

        // 5: landing, dropped user move, refused spawn
        gravity_tick = 1'b1;
        tick();
        gravity_tick = 1'b0;
        wait_run("land", MOVE_DOWN);
        answer(1'b0, 1);
        chk("land_pulse", 32'(landed), 32'd1);
        chk("land_act", 32'(block_active), 32'd0);
        chk("land_by", 32'(b_y), 32'd2);
        tick();
        chk("land_pulse_end", 32'(landed), 32'd0);
        user_valid = 1'b1;
        user_move  = MOVE_LEFT;
        #1;
        chk("drop_rdy", 32'(user_ready), 32'd1);
        tick();
        user_valid = 1'b0;
        tick();
        chk("drop_run", 32'(chk_if.check_run), 32'd0);
        chk("drop_busy", 32'(busy), 32'd0);
        appear_req = 1'b1;
        tick();
        appear_req = 1'b0;
        wait_run("over", MOVE_APPEAR);
        chk("over_spawn_bx", 32'(b_x), 32'd4);
        chk("over_spawn_by", 32'(b_y), 32'd0);
        answer(1'b0, 2);
        chk("over_pulse", 32'(game_over), 32'd1);
        chk("over_act", 32'(block_active), 32'd0);
        chk("over_bx", 32'(b_x), 32'd2);
        chk("over_by", 32'(b_y), 32'd2);
        tick();
        chk("over_pulse_end", 32'(game_over), 32'd0);

        // 6: silent checker triggers the watchdog
        appear_req = 1'b1;
        tick();
        appear_req = 1'b0;
        wait_run("respawn", MOVE_APPEAR);
        answer(1'b1, 1);
        chk("respawn_act", 32'(block_active), 32'd1);
        user_req(MOVE_LEFT);
        wait_run("silent", MOVE_LEFT);
        repeat (30) tick();
        chk("tmo_early", 32'(timeout_err), 32'd0);
        chk("tmo_early_busy", 32'(busy), 32'd1);
        tick();
        chk("tmo_set", 32'(timeout_err), 32'd1);
        chk("tmo_busy", 32'(busy), 32'd0);
        chk("tmo_bx", 32'(b_x), 32'd4);
        tick();
        chk("tmo_sticky", 32'(timeout_err), 32'd1);

        // Reset mid-WAIT, then a late check_done must be ignored
        user_req(MOVE_RIGHT);
        wait_run("rstmid", MOVE_RIGHT);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_if.check_done     = 1'b1;
        chk_if.check_can_move = 1'b1;
        tick();
        chk_if.check_done     = 1'b0;
        chk_if.check_can_move = 1'b0;
        tick();
        chk("late_bx", 32'(b_x), 32'd4);
        chk("late_by", 32'(b_y), 32'd0);
        chk("late_act", 32'(block_active), 32'd0);
        chk("late_busy", 32'(busy), 32'd0);
        chk("late_tmo", 32'(timeout_err), 32'd0);
        chk("late_run", 32'(chk_if.check_run), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
